// File: rtl/mod_reduce_134_pkg.sv
// Shared widths and FSM encoding for the 134-bit by 66-bit modular reducer.
package mod_reduce_134_pkg;

  localparam int unsigned PROD_W = 134;
  localparam int unsigned MOD_W  = 66;
  localparam int unsigned REM_W  = 67;
  localparam int unsigned CNT_W  = 8;

  // Bit index of the product MSB, the first bit consumed after accept.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(PROD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_reduce_134_sub_step.sv
// One restoring-division step: shift in a product bit, subtract M if it fits.
module mod_sub_step
  import mod_reduce_134_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [MOD_W-1:0] m_i,
  output logic [REM_W-1:0] rem_o
);

  // One bit wider than the remainder so the compare never sees a wrapped value.
  logic [REM_W:0] shifted;
  logic [REM_W:0] m_ext;
  logic [REM_W:0] diff;

  // Shift, compare against M and pick the reduced or unreduced value.
  always_comb begin
    shifted = {rem_i, bit_i};
    m_ext   = (REM_W + 1)'(m_i);
    diff    = shifted - m_ext;
    if (shifted >= m_ext) begin
      rem_o = REM_W'(diff);
    end else begin
      rem_o = REM_W'(shifted);
    end
  end

endmodule

// File: rtl/mod_reduce_134.sv
// Sequential C mod M reducer: MSB-first restoring division, STEPS bits per cycle.
module mod_reduce_134
  import mod_reduce_134_pkg::*;
#(
  parameter int unsigned STEPS  = 1,
  parameter int unsigned FF_OUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] C,
  input  logic [MOD_W-1:0]  M,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  R,
  output logic              err
);

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  c_q, c_d;
  logic [MOD_W-1:0]   m_q, m_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               m_zero;
  logic [REM_W-1:0]   chain [STEPS+1];
  logic [CNT_W-1:0]   bit_idx [STEPS];

  assign m_zero    = (m_q == '0);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign chain[0]  = rem_q;

  // Chain of STEPS single-bit steps; step g consumes product bit cnt_q-g.
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign bit_idx[g] = cnt_q - CNT_W'(g);
    mod_sub_step u_step (
      .rem_i (chain[g]),
      .bit_i (c_q[bit_idx[g]]),
      .m_i   (m_q),
      .rem_o (chain[g+1])
    );
  end

  // Next-state and datapath update for accept, iterate and hand-off.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    m_d     = m_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          c_d     = C;
          m_d     = M;
          rem_d   = '0;
          cnt_d   = CNT_START;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero modulus would let the remainder grow unbounded; keep it at 0.
        rem_d = m_zero ? '0 : chain[STEPS];
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(STEPS);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      m_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      m_q     <= m_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  if (FF_OUT != 0) begin : g_ff_out
    logic [MOD_W-1:0] r_q, r_d;
    logic             err_q, err_d;

    // Capture the final remainder on the edge that enters DONE.
    always_comb begin
      r_d   = r_q;
      err_d = err_q;
      if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
        r_d   = rem_d[MOD_W-1:0];
        err_d = m_zero;
      end
    end

    // Result registers, cleared by reset and held until the next result.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q   <= '0;
        err_q <= 1'b0;
      end else begin
        r_q   <= r_d;
        err_q <= err_d;
      end
    end

    assign R   = r_q;
    assign err = err_q;
  end else begin : g_comb_out
    // Remainder register is already final and stable in DONE; it stays 0 for M==0.
    assign R   = rem_q[MOD_W-1:0];
    assign err = (state_q == ST_DONE) && m_zero;
  end

endmodule

// File: tb/tb_mod_reduce_134.sv
// Directed and randomised checks for mod_reduce_134 (STEPS=1 registered, STEPS=2 combinational out).
module tb_mod_reduce_134;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid1, in_valid2;
  logic         out_ready1, out_ready2;
  logic [133:0] c;
  logic [65:0]  m;
  logic         in_ready1, in_ready2;
  logic         out_valid1, out_valid2;
  logic [65:0]  r1, r2;
  logic         err1, err2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mod_reduce_134 #(.STEPS(1), .FF_OUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .C(c), .M(m), .out_valid(out_valid1), .out_ready(out_ready1),
    .R(r1), .err(err1)
  );

  mod_reduce_134 #(.STEPS(2), .FF_OUT(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .C(c), .M(m), .out_valid(out_valid2), .out_ready(out_ready2),
    .R(r2), .err(err2)
  );

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Accept one operation on dut1, wait bounded for the result and check it.
  task automatic op1(input logic [133:0] cv, input logic [65:0] mv,
                     input logic [65:0] er, input logic ee, input string tag);
    int n;
    c = cv; m = mv; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    while (out_valid1 !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 134'(n), 134'd134);
    chk({tag, "_r"}, 134'(r1), 134'(er));
    chk({tag, "_err"}, 134'(err1), 134'(ee));
  endtask

  // Hand the dut1 result back and confirm the return to IDLE.
  task automatic rel1(input string tag);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk({tag, "_idle"}, 134'(in_ready1), 134'd1);
  endtask

  initial begin
    logic [159:0] tmp;
    logic [95:0]  tmpm;
    logic [133:0] rc, rem134;
    logic [65:0]  mv, er;
    logic         ee, bad, early;
    int           n;

    rst = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready1 = 1'b0; out_ready2 = 1'b0; c = '0; m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 134'(in_ready1), 134'd1);
    chk("rst_out_valid", 134'(out_valid1), 134'd0);
    chk("rst_r", 134'(r1), 134'd0);
    chk("rst_err", 134'(err1), 134'd0);
    chk("rst_r2", 134'(r2), 134'd0);
    chk("rst_err2", 134'(err2), 134'd0);

    // Basic reduction
    op1(134'd1000, 66'd7, 66'd6, 1'b0, "c1000_m7");
    rel1("c1000_m7");

    // All-ones product and modulus
    op1({134{1'b1}}, {66{1'b1}}, 66'd3, 1'b0, "ones");
    rel1("ones");

    // Same on the two-steps-per-cycle instance
    c = {134{1'b1}}; m = {66{1'b1}}; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (out_valid2 !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ones_s2_lat", 134'(n), 134'd67);
    chk("ones_s2_r", 134'(r2), 134'd3);
    chk("ones_s2_err", 134'(err2), 134'd0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    chk("ones_s2_idle", 134'(in_ready2), 134'd1);

    // Zero and unit modulus
    op1(134'd12345, 66'd0, 66'd0, 1'b1, "m0");
    rel1("m0");
    op1({67'h5_dead_beef_0123_4567, 67'h3_0f0f_f0f0_1234_5678}, 66'd1, 66'd0, 1'b0, "m1");
    rel1("m1");

    // Back-pressure: hold DONE for 10 cycles, then release with in_valid high
    op1(134'd1000, 66'd7, 66'd6, 1'b0, "hold");
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (r1 !== 66'd6 || in_ready1 !== 1'b0 || out_valid1 !== 1'b1) bad = 1'b1;
    end
    chk("hold_stable", 134'(bad), 134'd0);
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    chk("hold_release_idle", 134'(in_ready1), 134'd1);
    chk("hold_release_valid", 134'(out_valid1), 134'd0);
    @(posedge clk); #1;
    chk("hold_no_accept", 134'(in_ready1), 134'd1);

    // Reset in the middle of RUN aborts the operation
    c = 134'd999; m = 66'd5; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 134'(in_ready1), 134'd1);
    chk("abort_out_valid", 134'(out_valid1), 134'd0);
    chk("abort_r", 134'(r1), 134'd0);
    chk("abort_err", 134'(err1), 134'd0);
    bad = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (out_valid1 !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_result", 134'(bad), 134'd0);
    op1(134'd12345, 66'd100, 66'd45, 1'b0, "after_abort");
    rel1("after_abort");

    // Random back-to-back stream on the STEPS=2 instance with noisy inputs during RUN
    out_ready2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tmp  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rc   = tmp[133:0];
      tmpm = {$urandom, $urandom, $urandom};
      mv   = 66'(tmpm >> $urandom_range(0, 94));
      if (i % 50 == 7) mv = 66'd0;
      if (mv == 66'd0) begin
        er = 66'd0; ee = 1'b1;
      end else begin
        rem134 = rc % 134'(mv);
        er = rem134[65:0]; ee = 1'b0;
      end
      chk("rnd_ready", 134'(in_ready2), 134'd1);
      c = rc; m = mv; in_valid2 = 1'b1;
      @(posedge clk); #1;
      early = 1'b0;
      for (int k = 1; k <= 67; k++) begin
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c = tmp[133:0];
        m = tmp[65:0];
        in_valid2 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (k < 67 && out_valid2 !== 1'b0) early = 1'b1;
      end
      chk("rnd_early", 134'(early), 134'd0);
      chk("rnd_valid", 134'(out_valid2), 134'd1);
      chk("rnd_r", 134'(r2), 134'(er));
      chk("rnd_err", 134'(err2), 134'(ee));
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
    end
    chk("rnd_final_idle", 134'(in_ready2), 134'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mod_reduce_134.md
MOD_REDUCE_134 -- requirements
Module: mod_reduce_134

Interface
REQ-001 Parameter STEPS, default 1, SHALL set conditional shift-subtract steps per cycle; legal values are 1 and 2.
REQ-002 Parameter FF_OUT, default 1, SHALL select a registered output: 1 registers R/err, 0 drives them combinationally from the remainder register.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  C/M presented.
REQ-006 in_ready  output  1  block idle and accepting.
REQ-007 C  input  134  product to reduce (multiplier output width).
REQ-008 M  input  66  modulus.
REQ-009 out_valid  output  1  R/err valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 R  output  66  C mod M.
REQ-012 err  output  1  M was zero.

Function
REQ-013 FSM SHALL have three states, IDLE, RUN and DONE, and SHALL encode them with the encoding defined in the shared package.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On an edge with IDLE&&in_valid, C and M SHALL be latched, the 67-bit remainder cleared, the bit counter set to 133, and the FSM SHALL go to RUN.
REQ-016 Each RUN step SHALL compute rem' = {rem,C_bit} (MSB-first); if rem' >= {1'b0,M} then rem = rem' - M, else rem = rem'.
REQ-017 Remainder width SHALL be 67 bits; a rem < M invariant SHALL hold after every step, with no overflow.
REQ-018 RUN SHALL last 134/STEPS cycles, the counter SHALL decrement by STEPS, and the FSM SHALL enter DONE on the edge that consumes bit 0.
REQ-019 Latency SHALL be exactly 134/STEPS cycles from the accept edge to the first cycle with out_valid=1 (134 for STEPS=1, 67 for STEPS=2).
REQ-020 For M==0 the block SHALL take the same latency, then present err=1 and R=0.
REQ-021 For M==1 the result SHALL be R=0 and err=0.
REQ-022 In DONE, R/err SHALL hold stable until an edge with out_ready=1, then the FSM SHALL return to IDLE; the block SHALL NOT accept a new operation in that same cycle.
REQ-023 in_valid in RUN or DONE SHALL be ignored, and the latched C/M SHALL be unaffected by input changes after accept.
REQ-024 Throughput SHALL be one result per 134/STEPS+2 cycles, given out_ready held high.

Reset
REQ-025 rst SHALL force IDLE, in_ready=1, out_valid=0, R=0, err=0, and SHALL clear the counter and remainder.
REQ-026 rst asserted in RUN or DONE SHALL abort the operation with no result emitted; the first accept after reset SHALL behave as a fresh operation.

Structure
REQ-027 A shared package SHALL define the constants PROD_W=134, MOD_W=66 and REM_W=67, and the FSM state encoding.
REQ-028 One sub-module, mod_sub_step (a combinational single shift/compare/subtract), SHALL be instantiated STEPS times in a chain.

Verification
REQ-029 The bench SHALL cover: C=1000, M=7 -> R=6, err=0, with out_valid exactly 134 cycles after accept (STEPS=1).
REQ-030 The bench SHALL cover: C=2^134-1, M=2^66-1 -> R=(2^134-1) mod (2^66-1)=3, err=0; repeat with STEPS=2 -> the same R at latency 67.
REQ-031 The bench SHALL cover: M=0, any C -> err=1, R=0 after full latency; and M=1 -> R=0, err=0.
REQ-032 The bench SHALL cover: out_ready held low 10 cycles in DONE -> R stable and in_ready=0 throughout, then IDLE one edge after out_ready=1.
REQ-033 The bench SHALL cover: rst pulsed at RUN cycle 50 -> out_valid never rises for that operation, and the next operation C=12345, M=100 returns R=45.
REQ-034 The bench SHALL cover: 1000 random C/M pairs back-to-back against a reference model -> all R match, and in_valid toggling during RUN has no effect.
